// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, device ACK.
// Optional automatic retry on NACK/timeout is enabled by defining PS2_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int RETRIES        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       PS2_CLOCK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLOCK_OE,
  output logic       PS2_DATA_OE
);

  localparam int CNT_MAX0 = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYCLES) ? CNT_MAX0 : TIMEOUT_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAITIDLE, RELEASE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_cnt;
  logic [10:0]     frame_q;
  logic            clk_p0, clk_p1, clk_p2;
  logic            dat_p0, dat_p1;
  logic            accept, fall, to_hit, line_idle, fail;

`ifdef PS2_TX_RETRY_EN
  localparam int AW = $clog2(RETRIES + 2);
  logic [AW-1:0]   att;
  logic [7:0]      byte_q;
`endif

  // start(0), D0..D7, odd parity, stop(1); bit 0 goes out first
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // Stage p0/p1: pin synchronisers; p2 keeps the previous synced clock for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= PS2_CLOCK_IN;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= PS2_DATA_IN;
      dat_p1 <= dat_p0;
    end
  end

  always_comb begin
    accept    = (state == IDLE) && tx_valid && tx_ready;
    fall      = clk_p2 & ~clk_p1;
    to_hit    = ((state == SEND) || (state == ACK) || (state == WAITIDLE)) && (cnt == TO_LAST);
    line_idle = (state == WAITIDLE) && clk_p1 && dat_p1;
    fail      = !line_idle && (to_hit || ((state == ACK) && fall && dat_p1));
  end

  always_ff @(posedge clk) begin
    if (accept)
      frame_q <= frame_of(tx_data);
`ifdef PS2_TX_RETRY_EN
    else if (state == RELEASE)
      frame_q <= frame_of(byte_q);
`endif
    else if ((state == SEND) && fall && !fail)
      frame_q <= {1'b1, frame_q[10:1]};
`ifdef PS2_TX_RETRY_EN
    if (accept)
      byte_q <= tx_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx_ready     <= 1'b1;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
      PS2_CLOCK_OE <= 1'b0;
      PS2_DATA_OE  <= 1'b0;
      cnt          <= '0;
      bit_cnt      <= '0;
`ifdef PS2_TX_RETRY_EN
      att          <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (line_idle) begin
        state    <= IDLE;
        tx_done  <= 1'b1;
        busy     <= 1'b0;
        tx_ready <= 1'b1;
        cnt      <= '0;
`ifdef PS2_TX_RETRY_EN
        att      <= '0;
`endif
      end else if (fail) begin
        PS2_CLOCK_OE <= 1'b0;
        PS2_DATA_OE  <= 1'b0;
        cnt          <= '0;
`ifdef PS2_TX_RETRY_EN
        if (att < AW'(RETRIES)) begin
          att   <= att + 1'b1;
          state <= RELEASE;
        end else begin
          att      <= '0;
          state    <= IDLE;
          tx_err   <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
        end
`else
        state    <= IDLE;
        tx_err   <= 1'b1;
        busy     <= 1'b0;
        tx_ready <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: if (accept) begin
            state        <= INHIBIT;
            tx_ready     <= 1'b0;
            busy         <= 1'b1;
            PS2_CLOCK_OE <= 1'b1;
            PS2_DATA_OE  <= 1'b0;
            cnt          <= '0;
          end
          INHIBIT: if (cnt == INH_LAST) begin
            state       <= RTS;
            PS2_DATA_OE <= ~frame_q[0];
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          RTS: if (cnt == SET_LAST) begin
            state        <= SEND;
            PS2_CLOCK_OE <= 1'b0;
            cnt          <= '0;
            bit_cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          SEND: begin
            cnt <= cnt + 1'b1;
            if (fall) begin
              PS2_DATA_OE <= ~frame_q[1];
              bit_cnt     <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) state <= ACK;
            end
          end
          ACK: begin
            cnt <= cnt + 1'b1;
            if (fall) state <= WAITIDLE;
          end
          WAITIDLE: cnt <= cnt + 1'b1;
`ifdef PS2_TX_RETRY_EN
          RELEASE: begin
            state        <= INHIBIT;
            PS2_CLOCK_OE <= 1'b1;
            cnt          <= '0;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
